// File: rtl/dmem_responder.sv
// Single-port data memory responder for a core's load/store path. It accepts one request
// at a time and returns the response latency_p cycles later. The response is held until
// the core takes it.
package dmem_pkg;
    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;
endpackage

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned addr_width_p = 10,
    parameter int unsigned latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     to_mem_i,
    input  logic [31:0] data_mem_addr,
    output mem_out_s    from_mem_o,
    output logic [15:0] txn_count_o,
    output dmem_state_e state_o
);
    // Handshake: a request transfers on a rising edge where to_mem_i.valid and
    // from_mem_o.yumi are both high. A response transfers on a rising edge where
    // from_mem_o.valid and to_mem_i.yumi are both high. Until then, the response data is held.
    localparam int unsigned depth_lp     = 1 << addr_width_p;
    localparam logic [3:0]  busy_init_lp = (latency_p > 1) ? 4'(latency_p - 2) : 4'd0;

    dmem_state_e state_q, state_d;
    logic [3:0]  busy_cnt_q, busy_cnt_d;
    logic        valid_q, valid_d;
    logic [15:0] txn_count_q, txn_count_d;
    logic        wen_q, bnw_q;
    logic [1:0]  lane_q;
    logic [31:0] word_q;
    logic [31:0] mem_q [depth_lp];

    logic                    accept;
    logic [addr_width_p-1:0] word_idx;
    logic [1:0]              lane;
    logic                    unused_addr_bits;

    assign word_idx         = data_mem_addr[2 +: addr_width_p];
    assign lane             = data_mem_addr[1:0];
    assign unused_addr_bits = ^data_mem_addr[31:addr_width_p+2];
    // Qualifying with reset keeps yumi low and blocks array writes while reset is held.
    assign accept           = reset && (state_q == ST_IDLE) && to_mem_i.valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            busy_cnt_q  <= '0;
            valid_q     <= 1'b0;
            txn_count_q <= '0;
            wen_q       <= 1'b0;
            bnw_q       <= 1'b0;
            lane_q      <= '0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            busy_cnt_q  <= busy_cnt_d;
            valid_q     <= valid_d;
            txn_count_q <= txn_count_d;
            if (accept) begin
                wen_q  <= to_mem_i.wen;
                bnw_q  <= to_mem_i.byte_not_word;
                lane_q <= lane;
                word_q <= mem_q[word_idx];
            end
        end
    end

    // The array has no reset, so its contents survive a reset.
    always_ff @(posedge clk) begin
        if (accept && to_mem_i.wen) begin
            if (to_mem_i.byte_not_word) begin
                mem_q[word_idx][{lane, 3'b000} +: 8] <= to_mem_i.write_data[7:0];
            end else begin
                mem_q[word_idx] <= to_mem_i.write_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_cnt_d  = busy_cnt_q;
        txn_count_d = txn_count_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (latency_p == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d    = ST_BUSY;
                        busy_cnt_d = busy_init_lp;
                    end
                end
            end
            ST_BUSY: begin
                if (busy_cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    busy_cnt_d = busy_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (to_mem_i.yumi) begin
                    state_d     = ST_IDLE;
                    txn_count_d = txn_count_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_RESP);
    end

    always_comb begin
        from_mem_o      = '0;
        from_mem_o.yumi = accept;
        from_mem_o.valid = valid_q;
        if (wen_q) begin
            from_mem_o.read_data = 32'h0;
        end else if (bnw_q) begin
            from_mem_o.read_data = {24'h0, word_q[{lane_q, 3'b000} +: 8]};
        end else begin
            from_mem_o.read_data = word_q;
        end
    end

    assign txn_count_o = txn_count_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. It runs three instances with latency 2, 1 and 15 against a
// scoreboard of expected read data.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk;
    logic        reset;
    mem_in_s     to_mem   [3];
    logic [31:0] addr     [3];
    mem_out_s    from_mem [3];
    logic [15:0] txn      [3];
    dmem_state_e st       [3];

    int          lat_of [3] = '{2, 1, 15};
    logic [15:0] exp_cnt [3];
    logic [31:0] exp_q [$];
    logic [31:0] model_mem [0:31];
    int          n_vec;
    int          n_err;

    dmem_responder #(.addr_width_p(10), .latency_p(2)) u_dut0 (
        .clk(clk), .reset(reset), .to_mem_i(to_mem[0]), .data_mem_addr(addr[0]),
        .from_mem_o(from_mem[0]), .txn_count_o(txn[0]), .state_o(st[0])
    );
    dmem_responder #(.addr_width_p(10), .latency_p(1)) u_dut1 (
        .clk(clk), .reset(reset), .to_mem_i(to_mem[1]), .data_mem_addr(addr[1]),
        .from_mem_o(from_mem[1]), .txn_count_o(txn[1]), .state_o(st[1])
    );
    dmem_responder #(.addr_width_p(10), .latency_p(15)) u_dut2 (
        .clk(clk), .reset(reset), .to_mem_i(to_mem[2]), .data_mem_addr(addr[2]),
        .from_mem_o(from_mem[2]), .txn_count_o(txn[2]), .state_o(st[2])
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction on instance d. When hold > 0, the response is left untaken for hold
    // cycles while a conflicting store request is presented.
    task automatic do_txn(input int d, input logic wen, input logic bnw, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rexp, input int hold);
        int k;
        @(negedge clk);
        to_mem[d].write_data    = wd;
        to_mem[d].valid         = 1'b1;
        to_mem[d].wen           = wen;
        to_mem[d].byte_not_word = bnw;
        to_mem[d].yumi          = 1'b0;
        addr[d]                 = a;
        #1 check("yumi_on_valid", 32'(from_mem[d].yumi), 32'd1);
        exp_q.push_back(rexp);
        @(posedge clk);
        #1;
        if (hold == 0) to_mem[d].valid = 1'b0;
        check("yumi_after_accept", 32'(from_mem[d].yumi), 32'd0);
        k = 1;
        while (!from_mem[d].valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", 32'(k), 32'(lat_of[d]));
        check("rdata", from_mem[d].read_data, exp_q.pop_front());
        for (int h = 0; h < hold; h++) begin
            to_mem[d].wen        = 1'b1;
            to_mem[d].write_data = 32'hBAD0_BAD0;
            #1 check("hold_no_accept", 32'(from_mem[d].yumi), 32'd0);
            @(posedge clk);
            #1;
            check("hold_valid", 32'(from_mem[d].valid), 32'd1);
            check("hold_rdata", from_mem[d].read_data, rexp);
        end
        to_mem[d].yumi = 1'b1;
        #1 check("resp_no_accept", 32'(from_mem[d].yumi), 32'd0);
        @(posedge clk);
        #1;
        to_mem[d].yumi = 1'b0;
        exp_cnt[d] = exp_cnt[d] + 16'd1;
        check("txn_count", 32'(txn[d]), 32'(exp_cnt[d]));
        check("valid_drop", 32'(from_mem[d].valid), 32'd0);
        check("state_idle", 32'(st[d]), 32'(ST_IDLE));
        if (hold > 0) check("accept_after_hs", 32'(from_mem[d].yumi), 32'd1);
        to_mem[d].valid = 1'b0;
        to_mem[d].wen   = 1'b0;
    endtask

    // Start a word request on instance 0, then pull reset low while it is in BUSY.
    task automatic abort_in_busy(input logic wen, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        to_mem[0] = '{write_data: wd, valid: 1'b1, wen: wen, byte_not_word: 1'b0, yumi: 1'b0};
        addr[0]   = a;
        @(posedge clk);
        #1;
        check("abort_in_busy", 32'(st[0]), 32'(ST_BUSY));
        reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) exp_cnt[d] = 16'd0;
        check("abort_state", 32'(st[0]), 32'(ST_IDLE));
        check("abort_valid", 32'(from_mem[0].valid), 32'd0);
        check("abort_txn", 32'(txn[0]), 32'(exp_cnt[0]));
        check("abort_rdata", from_mem[0].read_data, 32'd0);
        check("abort_yumi", 32'(from_mem[0].yumi), 32'd0);
        @(posedge clk);
        #1 check("reset_hold_idle", 32'(st[0]), 32'(ST_IDLE));
        @(negedge clk);
        to_mem[0].valid = 1'b0;
        reset           = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1 check("abort_no_valid", 32'(from_mem[0].valid), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int          i;
        int          op;
        logic [1:0]  l;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] w;
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            to_mem[d]  = '0;
            addr[d]    = '0;
            exp_cnt[d] = 16'd0;
        end
        to_mem[0].valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_state", 32'(st[d]), 32'(ST_IDLE));
            check("rst_valid", 32'(from_mem[d].valid), 32'd0);
            check("rst_rdata", from_mem[d].read_data, 32'd0);
            check("rst_txn", 32'(txn[d]), 32'd0);
        end
        check("rst_yumi", 32'(from_mem[0].yumi), 32'd0);
        @(negedge clk);
        to_mem[0].valid = 1'b0;
        reset           = 1'b1;

        // Word store then load
        do_txn(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        do_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        // Byte lanes
        do_txn(0, 1'b1, 1'b0, 32'h10, 32'h11223344, 32'h0, 0);
        do_txn(0, 1'b1, 1'b1, 32'h13, 32'hFFFFFFA5, 32'h0, 0);
        do_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hA5223344, 0);
        do_txn(0, 1'b0, 1'b1, 32'h12, 32'h0, 32'h00000022, 0);
        do_txn(0, 1'b0, 1'b1, 32'h13, 32'h0, 32'h000000A5, 0);
        do_txn(0, 1'b0, 1'b1, 32'h11, 32'h0, 32'h00000033, 0);
        // Stalled response with a store presented; the store must be ignored
        do_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hA5223344, 5);
        do_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hA5223344, 0);
        // Address aliasing above the index width
        do_txn(0, 1'b1, 1'b0, 32'h1000, 32'h5, 32'h0, 0);
        do_txn(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h5, 0);
        do_txn(0, 1'b0, 1'b0, 32'h1010, 32'h0, 32'hA5223344, 0);

        // Random traffic over words 64..95, tracked by model_mem
        for (int n = 0; n < 32; n++) begin
            w            = $urandom;
            model_mem[n] = w;
            do_txn(0, 1'b1, 1'b0, 32'h100 + 32'(n * 4), w, 32'h0, 0);
        end
        for (int n = 0; n < 40; n++) begin
            i  = $urandom_range(31);
            l  = 2'($urandom_range(3));
            op = $urandom_range(3);
            wd = $urandom;
            a  = 32'h100 + 32'(i * 4) + {30'd0, l};
            case (op)
                0: begin
                    model_mem[i] = wd;
                    do_txn(0, 1'b1, 1'b0, a, wd, 32'h0, 0);
                end
                1: begin
                    model_mem[i][{l, 3'b000} +: 8] = wd[7:0];
                    do_txn(0, 1'b1, 1'b1, a, wd, 32'h0, 0);
                end
                2: do_txn(0, 1'b0, 1'b0, a, 32'h0, model_mem[i], 0);
                default: do_txn(0, 1'b0, 1'b1, a, 32'h0, {24'h0, model_mem[i][{l, 3'b000} +: 8]}, 0);
            endcase
        end

        // Reset during BUSY: the aborted load gives no response, and the aborted store is kept
        abort_in_busy(1'b0, 32'h10, 32'h0);
        do_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hA5223344, 0);
        abort_in_busy(1'b1, 32'h20, 32'hCAFEF00D);
        do_txn(0, 1'b0, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 0);

        // Latency 1 and 15
        do_txn(1, 1'b1, 1'b0, 32'h40, 32'h12345678, 32'h0, 0);
        do_txn(1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h12345678, 0);
        do_txn(1, 1'b0, 1'b1, 32'h41, 32'h0, 32'h00000056, 2);
        do_txn(2, 1'b1, 1'b0, 32'h44, 32'h0BADF00D, 32'h0, 0);
        do_txn(2, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0BADF00D, 3);

        // Counter wrap from a preset of FFFF
        @(negedge clk);
        force u_dut1.txn_count_q = 16'hFFFF;
        #1 release u_dut1.txn_count_q;
        exp_cnt[1] = 16'hFFFF;
        #1 check("preset_txn", 32'(txn[1]), 32'(exp_cnt[1]));
        do_txn(1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h12345678, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: addr_width_p, default 10, word-index width (memory depth 2^addr_width_p 32-bit words).
REQ-002 Parameter: latency_p, default 2, cycles from request accept to response valid; legal range 1..15.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; low forces reset state immediately.
REQ-005 to_mem_i  input  mem_in_s  request from core: write_data[31:0], valid, wen, byte_not_word, yumi.
REQ-006 data_mem_addr  input  32  byte address of request.
REQ-007 from_mem_o  output  mem_out_s  response to core: read_data[31:0], valid, yumi.
REQ-008 txn_count_o  output  16  completed-transaction counter.

Function
REQ-009 Three states: IDLE, BUSY, RESP.
REQ-010 IDLE: from_mem_o.yumi = to_mem_i.valid, combinational; all other states yumi = 0.
REQ-011 Accept edge: IDLE with to_mem_i.valid=1; latch wen, byte_not_word, address, write_data.
REQ-012 After accept: latency_p=1 -> RESP; else BUSY for latency_p-1 cycles, then RESP.
REQ-013 from_mem_o.valid is registered: 1 only in RESP; first high exactly latency_p cycles after accept edge.
REQ-014 RESP with to_mem_i.yumi=1 -> IDLE next cycle, txn_count_o increments; otherwise stays in RESP, read_data held stable.
REQ-015 to_mem_i.valid in BUSY/RESP: ignored, not accepted, no array access.
REQ-016 to_mem_i.yumi outside RESP: ignored.
REQ-017 No same-cycle accept in RESP: new request accepted no earlier than first IDLE cycle after handshake.
REQ-018 Word index = data_mem_addr[2 +: addr_width_p]; higher address bits ignored (aliasing wrap); lane = data_mem_addr[1:0].
REQ-019 Word store (wen=1, byte_not_word=0): full word written on accept edge; addr[1:0] ignored.
REQ-020 Byte store (wen=1, byte_not_word=1): write_data[7:0] to lane addr[1:0] (lane 0 = bits 7:0, little-endian); other lanes unchanged.
REQ-021 Word load: read_data = array word sampled on accept edge.
REQ-022 Byte load: read_data = zero-extended selected lane byte.
REQ-023 Store response: read_data = 32'h0; valid/yumi handshake identical to load.
REQ-024 Writes occur only on accept edge; no array write in BUSY/RESP.
REQ-025 txn_count_o wraps 16'hFFFF -> 16'h0000.

Reset
REQ-026 reset low: state IDLE, from_mem_o.valid=0, read_data=0, BUSY counter=0, txn_count_o=0, latched request cleared.
REQ-027 from_mem_o.yumi low while reset low regardless of to_mem_i.valid.
REQ-028 Array contents not reset; reset mid-transaction aborts it (no response, no count); a store already written on accept edge remains.
REQ-029 First accept possible on first rising edge with reset high.

Verification
REQ-030 latency_p=2: word store 32'hDEADBEEF @ addr 0x10, then word load @ 0x10 -> yumi same cycle as valid, valid 2 cycles later, read_data=32'hDEADBEEF, txn_count_o=2.
REQ-031 Byte store 8'hA5 @ 0x13 over word 32'h11223344 @ 0x10; word load -> 32'hA5223344; byte load @ 0x12 -> 32'h00000022.
REQ-032 Hold to_mem_i.yumi=0 for 5 cycles in RESP -> valid stays 1, read_data stable, no new accept despite valid_i=1; yumi=1 -> IDLE, next request accepted following cycle.
REQ-033 addr_width_p=10: store 32'h5 @ byte addr 0x1000 (word 1024) -> load @ 0x0 returns 32'h5.
REQ-034 reset low during BUSY of load -> valid never asserts, state IDLE, txn_count_o=0; post-reset load returns pre-reset array contents.
REQ-035 latency_p=1 and latency_p=15 -> valid exactly 1 and 15 cycles after accept; preset counter 16'hFFFF then one transaction -> 16'h0000.
